poly_dispatch_host: RTL and testbench
=====================================

Name: poly_dispatch_host

Overview:
- Host-side initiator for the polynomial-search UART command protocol; drives the same byte protocol the search-array interface answers.
- Accepts job words from a local queue, dispatches each as START / CAN_REC / data / END / ACCK.
- Services unsolicited SIG_FOUND reports by acknowledging and collecting the returned polynomial.
- Sits between a job FIFO / result sink and the byte-level Transmitter/Receiver pair.

Parameters:
- BYTES, 4, bytes per job/result word (word width BYTES*8)
- TIMEOUT, 24'd12_000_000, clk cycles allowed in any wait-for-reply state
- Protocol codes, fixed: START=F0, END=FF, ACCK=F1, ERR=EE, FAIL=F2, SIG_FOUND=F3, CAN_REC=F4

Ports:
- clk  in  1  system clock
- res  in  1  reset; synchronous, active-high
- job_word  in  BYTES*8  job to dispatch
- job_valid  in  1  job_word valid; held until job_done
- job_done  out  1  one-cycle pulse: job consumed; job_err qualifies it
- job_err  out  1  high with job_done when the device replied ERR
- tx_data  out  8  byte to transmit
- tx_valid  out  1  byte request to transmitter
- tx_load  in  1  one-cycle pulse: transmitter latched tx_data
- rx_data  in  8  received byte
- rx_take  in  1  one-cycle pulse: rx_data valid
- result_word  out  BYTES*8  polynomial reported by the device
- result_valid  out  1  one-cycle pulse with result_word
- fail_seen  out  1  one-cycle pulse on received FAIL
- timeout  out  1  one-cycle pulse on reply timeout
- proto_err  out  1  one-cycle pulse on malformed result frame
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts the frame; no job_done is issued.
- TX handshake: tx_valid and tx_data are held stable until the tx_load pulse. The FSM advances in the tx_load cycle. tx_valid drops the cycle after the last byte of a sequence.
- IDLE:
  - rx_take with F3 → SEND_FACK. This has priority over job_valid in the same cycle.
  - rx_take with F2 → fail_seen pulse; stay in IDLE.
  - Else job_valid → latch job_word into buff → SEND_START.
  - Other bytes are ignored.
- SEND_START: tx F0; on tx_load → WAIT_CAN; load the timeout counter.
- WAIT_CAN:
  - F4 → SEND_DATA, byte index i=1.
  - F3 → SEND_FACK; the job is retained and retried from IDLE afterwards.
  - F2 → fail_seen pulse; keep waiting.
  - Counter expiry → timeout pulse → IDLE; job not consumed.
- SEND_DATA:
  - tx buff[i*8-1 -: 8], i=1..BYTES (least-significant byte first).
  - Each tx_load increments i. After byte BYTES → SEND_END.
- SEND_END: tx FF; on tx_load → WAIT_ACK; reload the timeout counter.
- WAIT_ACK:
  - F1 → job_done=1, job_err=0 → IDLE.
  - EE → job_done=1, job_err=1 → IDLE.
  - F2 → fail_seen pulse; keep waiting.
  - Expiry → timeout → IDLE.
  - A device reply can take long (it waits for module ready); TIMEOUT must cover it.
- SEND_FACK: tx F1; on tx_load → RECV_POLY; i=1; clear rbuf; reload the timeout counter.
- RECV_POLY:
  - Each rx_take with i ≤ BYTES stores the byte at rbuf[i*8-1 -: 8] and increments i. Any value is legal, including F0–FF.
  - When i=BYTES+1:
    - FF → result_word=rbuf, result_valid pulse → IDLE.
    - Any other byte → proto_err pulse → IDLE.
  - Expiry → timeout → IDLE.
- Timeout counter: 24-bit, decrements each cycle in wait states, and reloads on every accepted rx byte.
- result_word holds its value until the next result.
- job_done and result_valid can never assert in the same cycle.

Optional Feature:
- Macro: POLY_DISPATCH_STATS_EN.
- When defined, the block adds four 16-bit saturating counters, each exported as an output port and cleared by res:
  - stat_ack: counts ACCK replies to jobs.
  - stat_err: counts ERR replies to jobs.
  - stat_found: counts good result frames.
  - stat_fail: counts FAIL bytes received.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Job 0x11223344; device returns F4 then F1 → tx sequence F0,44,33,22,11,FF; one job_done pulse with job_err=0.
- Same job; device returns EE after FF → job_done=1 with job_err=1; return to IDLE.
- IDLE, rx F3 → tx F1; rx AA,BB,CC,DD,FF → result_valid with result_word=0xDDCCBBAA.
- job_valid and F3 in the same cycle (and separately, F3 received in WAIT_CAN) → found frame serviced first, then job retried from F0 and completed with job_done.
- RECV_POLY gets 4 bytes then 0x00 → proto_err pulse, no result_valid; no reply in WAIT_CAN with TIMEOUT=100 → timeout at cycle 100, job_valid still pending.
- Assert res during SEND_DATA → all outputs 0 next cycle, no job_done; the next job sends F0 first.

Source files
------------

// File: rtl/poly_dispatch_host.sv
// Host-side initiator for the polynomial-search UART protocol: dispatches jobs and collects
// unsolicited SIG_FOUND results. Optional counters are enabled by POLY_DISPATCH_STATS_EN.
module poly_dispatch_host #(
    parameter int unsigned BYTES   = 4,
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic               clk,
    input  logic               res,
    input  logic [BYTES*8-1:0] job_word,
    input  logic               job_valid,
    output logic               job_done,
    output logic               job_err,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_load,
    input  logic [7:0]         rx_data,
    input  logic               rx_take,
    output logic [BYTES*8-1:0] result_word,
    output logic               result_valid,
    output logic               fail_seen,
    output logic               timeout,
    output logic               proto_err,
`ifdef POLY_DISPATCH_STATS_EN
    output logic [15:0]        stat_ack,
    output logic [15:0]        stat_err,
    output logic [15:0]        stat_found,
    output logic [15:0]        stat_fail,
`endif
    output logic               busy
);

    localparam int unsigned W  = BYTES * 8;
    localparam int unsigned IW = $clog2(BYTES + 1);

    localparam logic [IW-1:0] IdxOne  = IW'(1);
    localparam logic [IW-1:0] IdxLast = IW'(BYTES - 1);
    localparam logic [IW-1:0] IdxFull = IW'(BYTES);

    localparam logic [7:0] CodeStart  = 8'hF0;
    localparam logic [7:0] CodeEnd    = 8'hFF;
    localparam logic [7:0] CodeAck    = 8'hF1;
    localparam logic [7:0] CodeErr    = 8'hEE;
    localparam logic [7:0] CodeFail   = 8'hF2;
    localparam logic [7:0] CodeFound  = 8'hF3;
    localparam logic [7:0] CodeCanRec = 8'hF4;

    typedef enum logic [2:0] {
        StIdle,
        StSendStart,
        StWaitCan,
        StSendData,
        StSendEnd,
        StWaitAck,
        StSendFack,
        StRecvPoly
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   buff_q, buff_d;
    logic [W-1:0]   rbuf_q, rbuf_d;
    logic [W-1:0]   result_q, result_d;
    logic           result_valid_q, result_valid_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [23:0]    tmo_q, tmo_d;
    logic           expired;

    assign expired      = (tmo_q <= 24'd1);
    assign result_word  = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != StIdle);

    always_comb begin
        state_d        = state_q;
        buff_d         = buff_q;
        rbuf_d         = rbuf_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        idx_d          = idx_q;
        tmo_d          = tmo_q;
        tx_valid       = 1'b0;
        tx_data        = 8'h00;
        job_done       = 1'b0;
        job_err        = 1'b0;
        fail_seen      = 1'b0;
        timeout        = 1'b0;
        proto_err      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A pending SIG_FOUND report always wins over a new job.
                if (rx_take && rx_data == CodeFound) begin
                    state_d = StSendFack;
                end else if (rx_take && rx_data == CodeFail) begin
                    fail_seen = 1'b1;
                end else if (job_valid) begin
                    buff_d  = job_word;
                    state_d = StSendStart;
                end
            end

            StSendStart: begin
                tx_valid = 1'b1;
                tx_data  = CodeStart;
                if (tx_load) begin
                    state_d = StWaitCan;
                    tmo_d   = TIMEOUT;
                end
            end

            StWaitCan: begin
                tmo_d = tmo_q - 24'd1;
                if (rx_take) begin
                    tmo_d = TIMEOUT;
                    if (rx_data == CodeCanRec) begin
                        state_d = StSendData;
                        idx_d   = '0;
                    end else if (rx_data == CodeFound) begin
                        // Job stays on job_valid and is restarted from idle afterwards.
                        state_d = StSendFack;
                    end else if (rx_data == CodeFail) begin
                        fail_seen = 1'b1;
                    end
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end

            StSendData: begin
                tx_valid = 1'b1;
                tx_data  = buff_q[7:0];
                if (tx_load) begin
                    buff_d = buff_q >> 8;
                    idx_d  = idx_q + IdxOne;
                    if (idx_q == IdxLast) begin
                        state_d = StSendEnd;
                    end
                end
            end

            StSendEnd: begin
                tx_valid = 1'b1;
                tx_data  = CodeEnd;
                if (tx_load) begin
                    state_d = StWaitAck;
                    tmo_d   = TIMEOUT;
                end
            end

            StWaitAck: begin
                tmo_d = tmo_q - 24'd1;
                if (rx_take) begin
                    tmo_d = TIMEOUT;
                    if (rx_data == CodeAck) begin
                        job_done = 1'b1;
                        state_d  = StIdle;
                    end else if (rx_data == CodeErr) begin
                        job_done = 1'b1;
                        job_err  = 1'b1;
                        state_d  = StIdle;
                    end else if (rx_data == CodeFail) begin
                        fail_seen = 1'b1;
                    end
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end

            StSendFack: begin
                tx_valid = 1'b1;
                tx_data  = CodeAck;
                if (tx_load) begin
                    state_d = StRecvPoly;
                    idx_d   = '0;
                    rbuf_d  = '0;
                    tmo_d   = TIMEOUT;
                end
            end

            StRecvPoly: begin
                tmo_d = tmo_q - 24'd1;
                if (rx_take) begin
                    tmo_d = TIMEOUT;
                    if (idx_q != IdxFull) begin
                        // Shift in from the top so the first byte ends up least significant.
                        rbuf_d = (rbuf_q >> 8) | (W'(rx_data) << (W - 8));
                        idx_d  = idx_q + IdxOne;
                    end else if (rx_data == CodeEnd) begin
                        result_d       = rbuf_q;
                        result_valid_d = 1'b1;
                        state_d        = StIdle;
                    end else begin
                        proto_err = 1'b1;
                        state_d   = StIdle;
                    end
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase

        if (res) begin
            tx_valid  = 1'b0;
            tx_data   = 8'h00;
            job_done  = 1'b0;
            job_err   = 1'b0;
            fail_seen = 1'b0;
            timeout   = 1'b0;
            proto_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q        <= StIdle;
            buff_q         <= '0;
            rbuf_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            idx_q          <= '0;
            tmo_q          <= '0;
        end else begin
            state_q        <= state_d;
            buff_q         <= buff_d;
            rbuf_q         <= rbuf_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            idx_q          <= idx_d;
            tmo_q          <= tmo_d;
        end
    end

`ifdef POLY_DISPATCH_STATS_EN
    logic [15:0] stat_ack_q, stat_err_q, stat_found_q, stat_fail_q;

    assign stat_ack   = stat_ack_q;
    assign stat_err   = stat_err_q;
    assign stat_found = stat_found_q;
    assign stat_fail  = stat_fail_q;

    always_ff @(posedge clk) begin
        if (res) begin
            stat_ack_q   <= '0;
            stat_err_q   <= '0;
            stat_found_q <= '0;
            stat_fail_q  <= '0;
        end else begin
            if (job_done && !job_err && stat_ack_q != 16'hFFFF) begin
                stat_ack_q <= stat_ack_q + 16'd1;
            end
            if (job_done && job_err && stat_err_q != 16'hFFFF) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
            if (result_valid_d && stat_found_q != 16'hFFFF) begin
                stat_found_q <= stat_found_q + 16'd1;
            end
            if (fail_seen && stat_fail_q != 16'hFFFF) begin
                stat_fail_q <= stat_fail_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_poly_dispatch_host.sv
// Self-checking bench for poly_dispatch_host: device/transmitter behaviour is modelled here and
// expected byte frames and results are derived from the protocol rules.
module tb_poly_dispatch_host;

    localparam int unsigned BYTES = 4;
    localparam int unsigned W     = BYTES * 8;
    localparam int unsigned TMO   = 100;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic [W-1:0] job_word = '0;
    logic         job_valid = 1'b0;
    logic         job_done, job_err;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_load = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_take = 1'b0;
    logic [W-1:0] result_word;
    logic         result_valid, fail_seen, timeout, proto_err, busy;

    poly_dispatch_host #(
        .BYTES   (BYTES),
        .TIMEOUT (24'(TMO))
    ) dut (
        .clk          (clk),
        .res          (res),
        .job_word     (job_word),
        .job_valid    (job_valid),
        .job_done     (job_done),
        .job_err      (job_err),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_load      (tx_load),
        .rx_data      (rx_data),
        .rx_take      (rx_take),
        .result_word  (result_word),
        .result_valid (result_valid),
        .fail_seen    (fail_seen),
        .timeout      (timeout),
        .proto_err    (proto_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: log of latched bytes, newest in the low byte.
    logic [255:0] tx_vec = '0;
    int           tx_cnt = 0;
    int           load_cyc = 0;
    bit           wait_err = 1'b0;

    initial begin
        int dly = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!res && tx_valid && dly == 0) begin
                tx_load  = 1'b1;
                tx_vec   = {tx_vec[247:0], tx_data};
                tx_cnt   = tx_cnt + 1;
                load_cyc = cyc;
                dly      = $urandom_range(0, 2);
            end else begin
                tx_load = 1'b0;
                if (tx_valid && dly > 0) dly = dly - 1;
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    int           n_done = 0, n_res = 0, n_fail = 0, n_tmo = 0, n_proto = 0, n_both = 0;
    int           tmo_cyc = 0;
    logic         last_err = 1'b0;
    logic [W-1:0] last_res = '0;

    always @(negedge clk) begin
        if (job_done) begin
            n_done   = n_done + 1;
            last_err = job_err;
        end
        if (result_valid) begin
            n_res    = n_res + 1;
            last_res = result_word;
        end
        if (fail_seen) n_fail = n_fail + 1;
        if (timeout) begin
            n_tmo   = n_tmo + 1;
            tmo_cyc = cyc;
        end
        if (proto_err) n_proto = n_proto + 1;
        if (job_done && result_valid) n_both = n_both + 1;
    end

    function automatic logic [255:0] app(input logic [255:0] v, input logic [7:0] b);
        return {v[247:0], b};
    endfunction

    // Reference frame for one job: START, word bytes LSB first, END.
    function automatic logic [255:0] job_frame(input logic [255:0] v, input logic [W-1:0] w);
        logic [255:0] r;
        r = app(v, 8'hF0);
        for (int i = 0; i < int'(BYTES); i++) r = app(r, w[i*8 +: 8]);
        r = app(r, 8'hFF);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_take = 1'b1;
        tick(1);
        rx_take = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_cnt < n && k < 200) begin
            tick(1);
            k++;
        end
        if (tx_cnt < n) wait_err = 1'b1;
        tick(1);
    endtask

    task automatic clear_log();
        tx_vec = '0;
        tx_cnt = 0;
    endtask

    task automatic do_job(input logic [W-1:0] w, input logic [7:0] reply, input int base,
                          input bit inj_fail);
        job_word  = w;
        job_valid = 1'b1;
        wait_tx(base + 1);
        if (inj_fail) send_rx(8'hF2);
        send_rx(8'hF4);
        wait_tx(base + 2 + int'(BYTES));
        if (inj_fail) send_rx(8'hF2);
        send_rx(reply);
        job_valid = 1'b0;
        tick(2);
    endtask

    task automatic do_found(input logic [W-1:0] poly, input logic [7:0] term, input int base);
        send_rx(8'hF3);
        wait_tx(base + 1);
        for (int i = 0; i < int'(BYTES); i++) send_rx(poly[i*8 +: 8]);
        send_rx(term);
        tick(2);
    endtask

    task automatic check_waits(input string name);
        checks++;
        if (wait_err) $display("FAIL %s tx wait expired got %0d bytes", name, tx_cnt);
        else passed++;
        wait_err = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        tick(2);
        checks++;
        if ({busy, tx_valid, job_done, job_err, result_valid, fail_seen, timeout, proto_err}
            !== 8'h00) $display("FAIL reset_ctrl got %b exp 00000000",
            {busy, tx_valid, job_done, job_err, result_valid, fail_seen, timeout, proto_err});
        else passed++;
        checks++;
        if (result_word !== '0) $display("FAIL reset_result got %h exp 0", result_word);
        else passed++;
        res = 1'b0;
        tick(2);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy got %b exp 0", busy);
        else passed++;
    endtask

    task automatic test_job(input logic [W-1:0] w, input logic [7:0] reply, input string name);
        int d0 = n_done;
        clear_log();
        do_job(w, reply, 0, 1'b0);
        check_waits(name);
        checks++;
        if (tx_cnt != 6 || tx_vec !== job_frame('0, w))
            $display("FAIL %s_tx got %0d:%h exp 6:%h", name, tx_cnt, tx_vec, job_frame('0, w));
        else passed++;
        checks++;
        if (n_done - d0 != 1) $display("FAIL %s_done got %0d exp 1", name, n_done - d0);
        else passed++;
        checks++;
        if (last_err !== (reply == 8'hEE)) $display("FAIL %s_err got %b exp %b", name, last_err,
            reply == 8'hEE);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s_idle busy got %b exp 0", name, busy);
        else passed++;
    endtask

    task automatic test_found(input logic [W-1:0] poly, input string name);
        int r0 = n_res;
        int d0 = n_done;
        clear_log();
        do_found(poly, 8'hFF, 0);
        check_waits(name);
        checks++;
        if (tx_cnt != 1 || tx_vec[7:0] !== 8'hF1)
            $display("FAIL %s_tx got %0d:%h exp 1:f1", name, tx_cnt, tx_vec[7:0]);
        else passed++;
        checks++;
        if (n_res - r0 != 1 || last_res !== poly)
            $display("FAIL %s_result got %0d:%h exp 1:%h", name, n_res - r0, last_res, poly);
        else passed++;
        tick(4);
        checks++;
        if (result_word !== poly || n_done != d0)
            $display("FAIL %s_hold got %h/%0d exp %h/%0d", name, result_word, n_done, poly, d0);
        else passed++;
    endtask

    task automatic test_fail_idle();
        int f0 = n_fail;
        send_rx(8'hF2);
        tick(1);
        checks++;
        if (n_fail - f0 != 1 || busy !== 1'b0)
            $display("FAIL fail_idle got %0d/%b exp 1/0", n_fail - f0, busy);
        else passed++;
    endtask

    task automatic test_found_priority();
        logic [W-1:0] w = 32'hCAFE0123;
        logic [W-1:0] p = 32'h0BADF00D;
        logic [255:0] exp;
        int           d0 = n_done;
        int           r0 = n_res;
        clear_log();
        job_word  = w;
        job_valid = 1'b1;
        do_found(p, 8'hFF, 0);
        do_job(w, 8'hF1, 1, 1'b0);
        check_waits("prio");
        exp = job_frame(app('0, 8'hF1), w);
        checks++;
        if (tx_cnt != 7 || tx_vec !== exp)
            $display("FAIL prio_tx got %0d:%h exp 7:%h", tx_cnt, tx_vec, exp);
        else passed++;
        checks++;
        if (n_res - r0 != 1 || last_res !== p || n_done - d0 != 1)
            $display("FAIL prio_events got %0d:%h:%0d exp 1:%h:1", n_res - r0, last_res,
                     n_done - d0, p);
        else passed++;
    endtask

    task automatic test_found_in_wait_can();
        logic [W-1:0] w = 32'h5A5AA5A5;
        logic [W-1:0] p = 32'hF0F1F2FF;
        logic [255:0] exp;
        int           d0 = n_done;
        clear_log();
        job_word  = w;
        job_valid = 1'b1;
        wait_tx(1);
        do_found(p, 8'hFF, 1);
        do_job(w, 8'hF1, 2, 1'b0);
        check_waits("waitcan_found");
        exp = job_frame(app(app('0, 8'hF0), 8'hF1), w);
        checks++;
        if (tx_cnt != 8 || tx_vec !== exp)
            $display("FAIL waitcan_found_tx got %0d:%h exp 8:%h", tx_cnt, tx_vec, exp);
        else passed++;
        checks++;
        if (last_res !== p || n_done - d0 != 1)
            $display("FAIL waitcan_found_ev got %h:%0d exp %h:1", last_res, n_done - d0, p);
        else passed++;
    endtask

    task automatic test_proto_err();
        logic [W-1:0] prev = result_word;
        int           r0 = n_res;
        int           p0 = n_proto;
        clear_log();
        do_found(32'h01020304, 8'h00, 0);
        check_waits("proto");
        checks++;
        if (n_proto - p0 != 1 || n_res != r0)
            $display("FAIL proto_err got %0d/%0d exp 1/0", n_proto - p0, n_res - r0);
        else passed++;
        checks++;
        if (result_word !== prev || busy !== 1'b0)
            $display("FAIL proto_hold got %h/%b exp %h/0", result_word, busy, prev);
        else passed++;
    endtask

    task automatic test_timeout();
        logic [W-1:0] w = 32'h89ABCDEF;
        int           t0 = n_tmo;
        int           d0 = n_done;
        int           lc;
        int           k = 0;
        clear_log();
        job_word  = w;
        job_valid = 1'b1;
        wait_tx(1);
        lc = load_cyc;
        while (n_tmo == t0 && k < 300) begin
            tick(1);
            k++;
        end
        checks++;
        if (n_tmo - t0 != 1 || tmo_cyc - lc != int'(TMO))
            $display("FAIL timeout_at got %0d/%0d exp 1/%0d", n_tmo - t0, tmo_cyc - lc, TMO);
        else passed++;
        checks++;
        if (n_done != d0) $display("FAIL timeout_done got %0d exp 0", n_done - d0);
        else passed++;
        // Job is still pending, so the device sees a fresh START.
        wait_tx(2);
        checks++;
        if (tx_cnt != 2 || tx_vec[7:0] !== 8'hF0)
            $display("FAIL timeout_retry got %0d:%h exp 2:f0", tx_cnt, tx_vec[7:0]);
        else passed++;
        send_rx(8'hF4);
        wait_tx(2 + int'(BYTES) + 1);
        send_rx(8'hF1);
        job_valid = 1'b0;
        tick(2);
        check_waits("timeout");
        checks++;
        if (n_done - d0 != 1) $display("FAIL timeout_complete got %0d exp 1", n_done - d0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w = 32'hDEADBEEF;
        int           d0 = n_done;
        clear_log();
        job_word  = w;
        job_valid = 1'b1;
        wait_tx(1);
        send_rx(8'hF4);
        wait_tx(3);
        res = 1'b1;
        tick(1);
        checks++;
        if ({busy, tx_valid, job_done, result_valid, timeout, proto_err} !== 6'h00 ||
            result_word !== '0)
            $display("FAIL reset_mid_out got %b/%h exp 000000/0",
                     {busy, tx_valid, job_done, result_valid, timeout, proto_err}, result_word);
        else passed++;
        res = 1'b0;
        clear_log();
        checks++;
        if (n_done != d0) $display("FAIL reset_mid_done got %0d exp 0", n_done - d0);
        else passed++;
        do_job(w, 8'hF1, 0, 1'b0);
        check_waits("reset_mid");
        checks++;
        if (tx_cnt != 6 || tx_vec !== job_frame('0, w))
            $display("FAIL reset_mid_tx got %0d:%h exp 6:%h", tx_cnt, tx_vec, job_frame('0, w));
        else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int d0 = n_done;
            int r0 = n_res;
            int f0 = n_fail;
            clear_log();
            if ($urandom_range(0, 1) == 1) begin
                logic [W-1:0] w   = W'($urandom);
                logic [7:0]   rep = ($urandom_range(0, 1) == 1) ? 8'hEE : 8'hF1;
                bit           inj = 1'($urandom_range(0, 1));
                do_job(w, rep, 0, inj);
                checks++;
                if (tx_vec !== job_frame('0, w) || n_done - d0 != 1 ||
                    last_err !== (rep == 8'hEE) || n_fail - f0 != (inj ? 2 : 0))
                    $display("FAIL rand_job[%0d] got %h/%0d/%b/%0d exp %h/1/%b/%0d", it, tx_vec,
                             n_done - d0, last_err, n_fail - f0, job_frame('0, w),
                             rep == 8'hEE, inj ? 2 : 0);
                else passed++;
            end else begin
                logic [W-1:0] p = W'($urandom);
                do_found(p, 8'hFF, 0);
                checks++;
                if (tx_vec[7:0] !== 8'hF1 || tx_cnt != 1 || n_res - r0 != 1 ||
                    result_word !== p)
                    $display("FAIL rand_found[%0d] got %0d/%h exp 1/%h", it, n_res - r0,
                             result_word, p);
                else passed++;
            end
        end
        check_waits("random");
    endtask

    initial begin
        test_reset();
        test_job(32'h11223344, 8'hF1, "job_ack");
        test_job(32'h11223344, 8'hEE, "job_err");
        test_found(32'hDDCCBBAA, "found");
        test_fail_idle();
        test_found_priority();
        test_found_in_wait_can();
        test_proto_err();
        test_timeout();
        test_reset_mid();
        test_random();
        checks++;
        if (n_both != 0) $display("FAIL done_and_result got %0d exp 0", n_both);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit got expired exp finished");
        $fatal(1, "time limit");
    end

endmodule
